// File: rtl/pixel_coord_gen.sv
// pixel_coord_gen: raster scanner that walks a WIDTH x HEIGHT frame row-major
// and presents one Q16.16 screen coordinate pair per pixel on a valid/ready
// handshake. Coordinates are built by incremental adds, so no multipliers.
module pixel_coord_gen #(
  parameter int              WIDTH   = 640,
  parameter int              HEIGHT  = 480,
  parameter int              FP_W    = 32,
  parameter logic [FP_W-1:0] X_START = 32'hFFFF0000,
  parameter logic [FP_W-1:0] X_STEP  = 32'h00000CCD,
  parameter logic [FP_W-1:0] Y_START = 32'h0000C000,
  parameter logic [FP_W-1:0] Y_STEP  = 32'hFFFFFCCD,
  localparam int             XW      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int             YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            out_ready,
  output logic [FP_W-1:0] screen_x,
  output logic [FP_W-1:0] screen_y,
  output logic [XW-1:0]   px_x,
  output logic [YW-1:0]   px_y,
  output logic            sof,
  output logic            eol,
  output logic            coords_valid,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [XW-1:0]   X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST = YW'(HEIGHT - 1);
  localparam logic [FP_W-1:0] FP_ZERO = {FP_W{1'b0}};

  state_t          state_q, state_d;
  logic [FP_W-1:0] sx_q, sx_d;
  logic [FP_W-1:0] sy_q, sy_d;
  logic [XW-1:0]   px_x_q, px_x_d;
  logic [YW-1:0]   px_y_q, px_y_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            xfer_s;
  logic            last_s;

  assign xfer_s = (state_q == ST_RUN) && out_ready;
  assign last_s = (px_x_q == X_LAST) && (px_y_q == Y_LAST);

  // Next-state, coordinate stepping and decoded flags for the next cycle.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    px_x_d  = px_x_q;
    px_y_d  = px_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sx_d    = X_START;
          sy_d    = Y_START;
          px_x_d  = {XW{1'b0}};
          px_y_d  = {YW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          if (last_s) begin
            // Frame complete: outputs return to zero while in DONE.
            state_d = ST_DONE;
            sx_d    = FP_ZERO;
            sy_d    = FP_ZERO;
            px_x_d  = {XW{1'b0}};
            px_y_d  = {YW{1'b0}};
          end else if (px_x_q == X_LAST) begin
            // Row wrap reloads X so per-row rounding error never accumulates.
            sx_d   = X_START;
            sy_d   = sy_q + Y_STEP;
            px_x_d = {XW{1'b0}};
            px_y_d = px_y_q + YW'(1);
          end else begin
            sx_d   = sx_q + X_STEP;
            px_x_d = px_x_q + XW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sx_d    = FP_ZERO;
        sy_d    = FP_ZERO;
        px_x_d  = {XW{1'b0}};
        px_y_d  = {YW{1'b0}};
      end
    endcase
    valid_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    sof_d   = valid_d && (px_x_d == {XW{1'b0}}) && (px_y_d == {YW{1'b0}});
    eol_d   = valid_d && (px_x_d == X_LAST);
  end

  // State, accumulators and registered output flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sx_q    <= FP_ZERO;
      sy_q    <= FP_ZERO;
      px_x_q  <= {XW{1'b0}};
      px_y_q  <= {YW{1'b0}};
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      px_x_q  <= px_x_d;
      px_y_q  <= px_y_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign screen_x     = sx_q;
  assign screen_y     = sy_q;
  assign px_x         = px_x_q;
  assign px_y         = px_y_q;
  assign sof          = sof_q;
  assign eol          = eol_q;
  assign coords_valid = valid_q;
  assign busy         = valid_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Testbench for pixel_coord_gen on a 4x3 frame with hand-computed coordinates.
module tb_pixel_coord_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        out_ready;
  logic [31:0] screen_x;
  logic [31:0] screen_y;
  logic [1:0]  px_x;
  logic [1:0]  px_y;
  logic        sof;
  logic        eol;
  logic        coords_valid;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ex_px_x;
    logic [1:0]  ex_px_y;
    logic [31:0] ex_sx;
    logic [31:0] ex_sy;
    logic        ex_sof;
    logic        ex_eol;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] sx_tab [4];
  logic [31:0] sy_tab [3];

  pixel_coord_gen #(
    .WIDTH   (4),
    .HEIGHT  (3),
    .FP_W    (32),
    .X_START (32'hFFFF0000),
    .X_STEP  (32'h00008000),
    .Y_START (32'h00010000),
    .Y_STEP  (32'hFFFF8000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .out_ready    (out_ready),
    .screen_x     (screen_x),
    .screen_y     (screen_y),
    .px_x         (px_x),
    .px_y         (px_y),
    .sof          (sof),
    .eol          (eol),
    .coords_valid (coords_valid),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic exp_done);
    chk({tag, "_valid"}, 64'(coords_valid), 64'(1'b0));
    chk({tag, "_busy"},  64'(busy),         64'(1'b0));
    chk({tag, "_done"},  64'(frame_done),   64'(exp_done));
    chk({tag, "_sof"},   64'(sof),          64'(1'b0));
    chk({tag, "_eol"},   64'(eol),          64'(1'b0));
    chk({tag, "_sx"},    64'(screen_x),     64'h0);
    chk({tag, "_sy"},    64'(screen_y),     64'h0);
  endtask

  // Runs one frame: waits for valid (expected after exp_wait negedges), checks
  // every presented word against the table (stall cycles must repeat it),
  // then checks the DONE cycle. mode: 0 ready=1, 1 random ready,
  // 2 ready=1 with start pulsed mid-run, 3 ready=1 with start held high.
  task automatic run_frame(input int mode, input int exp_wait);
    int idx    = 0;
    int waited = 0;
    int cycles = 0;
    while (waited < 6) begin
      @(negedge clk);
      waited++;
      if (coords_valid === 1'b1) break;
    end
    chk("first_valid_latency", 64'(waited), 64'(exp_wait));
    if (coords_valid !== 1'b1) return;
    while (cycles < 200) begin
      cycles++;
      chk("run_valid", 64'(coords_valid), 64'(1'b1));
      chk("run_busy",  64'(busy),         64'(1'b1));
      chk("run_done",  64'(frame_done),   64'(1'b0));
      chk("px_x",      64'(px_x),         64'(vecs[idx].ex_px_x));
      chk("px_y",      64'(px_y),         64'(vecs[idx].ex_px_y));
      chk("screen_x",  64'(screen_x),     64'(vecs[idx].ex_sx));
      chk("screen_y",  64'(screen_y),     64'(vecs[idx].ex_sy));
      chk("sof",       64'(sof),          64'(vecs[idx].ex_sof));
      chk("eol",       64'(eol),          64'(vecs[idx].ex_eol));
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else           out_ready = 1'b1;
      if (mode == 3)                     start = 1'b1;
      else if (mode == 2 && idx == 5)    start = 1'b1;
      else                               start = 1'b0;
      if (out_ready) idx++;
      if (idx == 12) break;
      @(negedge clk);
    end
    chk("transfer_count", 64'(idx), 64'd12);
    @(negedge clk);
    chk_idle_outputs("done_cycle", 1'b1);
  endtask

  initial begin
    sx_tab[0] = 32'hFFFF0000; sx_tab[1] = 32'hFFFF8000;
    sx_tab[2] = 32'h00000000; sx_tab[3] = 32'h00008000;
    sy_tab[0] = 32'h00010000; sy_tab[1] = 32'h00008000; sy_tab[2] = 32'h00000000;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        vecs[r*4+c] = '{ex_px_x: 2'(c), ex_px_y: 2'(r), ex_sx: sx_tab[c], ex_sy: sy_tab[r],
                        ex_sof: (r == 0 && c == 0), ex_eol: (c == 3)};
      end
    end

    // 1: reset state
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset", 1'b0);
    chk("reset_px_x", 64'(px_x), 64'h0);
    chk("reset_px_y", 64'(px_y), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle", 1'b0);

    // 2: full-rate frame
    start = 1'b1;
    run_frame(0, 1);
    @(negedge clk);
    chk("done_pulse_width", 64'(frame_done), 64'(1'b0));

    // 3: random backpressure
    start = 1'b1;
    run_frame(1, 1);
    @(negedge clk);
    chk("done_pulse_width_rnd", 64'(frame_done), 64'(1'b0));

    // 4: start pulsed during RUN is ignored
    start = 1'b1;
    run_frame(2, 1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle_outputs("no_restart", 1'b0);
    end

    // 5: reset after five transfers aborts the frame
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_px_x", 64'(px_x), 64'd1);
    chk("pre_abort_px_y", 64'(px_y), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("abort", 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_outputs("post_abort", 1'b0);
    end
    start = 1'b1;
    run_frame(0, 1);

    // 6: start held high gives back-to-back frames (DONE then IDLE between)
    @(negedge clk);
    start = 1'b1;
    run_frame(3, 1);
    run_frame(3, 2);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
